fp_addsub_pipe: RTL and testbench

- Parametrised, 3-stage pipelined IEEE-754-style floating-point adder/subtractor.
- Successor to the team's combinational single-precision adder. Adds:
  - clocked pipeline with valid/ready backpressure
  - per-transaction add/sub select
  - generic exponent/mantissa widths
  - round-to-nearest-even
  - zero/Inf/NaN/overflow handling
- Feeds the Q-value update datapath; one result per clock when not stalled.

---
 rtl/fp_addsub_pipe.sv | 268 ++++++++++++++++++++++++++
 tb/tb_fp_addsub_pipe.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_addsub_pipe.sv
// fp_addsub_pipe
//   Three-stage pipelined floating-point adder/subtractor with
//   round-to-nearest-even and zero/Inf/NaN/overflow handling.
//   Denormal operands are flushed to zero. Results that underflow are
//   also flushed to zero.
//   Stage 1 unpacks and aligns the operands. Stage 2 adds or subtracts
//   the mantissas. Stage 3 normalises, rounds and registers the result.
//
// Parameters
//   EXP_W : exponent field width (bias = 2^(EXP_W-1)-1)
//   MAN_W : stored fraction width (hidden bit implicit)
//
// Ports
//   clk       : rising-edge clock
//   rst_n     : asynchronous active-low reset
//   in_a      : operand A {sign, exp, frac}
//   in_b      : operand B {sign, exp, frac}
//   op_sub    : 1 = A-B, 0 = A+B; sampled together with valid_in
//   valid_in  : operands valid
//   ready_out : block can accept operands
//   result    : rounded result
//   valid_out : result valid
//   ready_in  : downstream accepts the result
//   flags     : {invalid, overflow, underflow, inexact}; aligned with result.
//               This port exists only when FP_ADDSUB_FLAGS_EN is defined.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. That applies to valid_in/ready_out and to valid_out/ready_in.
// The whole pipe advances together whenever the output register is empty
// or is being drained. Otherwise every stage holds, bubbles included.
module fp_addsub_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [EXP_W+MAN_W:0] in_a,
    input  logic [EXP_W+MAN_W:0] in_b,
    input  logic                 op_sub,
    input  logic                 valid_in,
    output logic                 ready_out,
    output logic [EXP_W+MAN_W:0] result,
    output logic                 valid_out,
    input  logic                 ready_in
`ifdef FP_ADDSUB_FLAGS_EN
    ,
    output logic [3:0]           flags
`endif
);
    localparam int W   = EXP_W + MAN_W + 1;
    localparam int MW  = MAN_W + 4;          // {hidden, frac, G, R, S}
    localparam int SW  = MAN_W + 5;          // mantissa sum incl. carry
    localparam int LZW = $clog2(MW + 1);
    localparam int EW  = EXP_W + 2;          // exponent headroom; MSB set = negative
    localparam logic [EXP_W-1:0] EXP_ONES = '1;
    localparam logic [W-1:0] QNAN = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

    logic en;
    logic s1_valid, s2_valid, s3_valid;

    // Stage 1 registers
    logic          s1_spec, s1_sign, s1_sub;
    logic [W-1:0]  s1_spec_val;
    logic [EXP_W-1:0] s1_exp;
    logic [MW-1:0] s1_mx, s1_my;
    // Stage 2 registers
    logic          s2_spec, s2_sign;
    logic [W-1:0]  s2_spec_val;
    logic [EXP_W-1:0] s2_exp;
    logic [SW-1:0] s2_sum;
`ifdef FP_ADDSUB_FLAGS_EN
    logic s1_inv, s2_inv;
    logic s3_ovf, s3_unf, s3_inx;
`endif

    assign en        = ~s3_valid | ready_in;
    assign ready_out = en;
    assign valid_out = s3_valid;

    // ---------------- Stage 1: unpack / classify / align ----------------
    logic a_sign, b_sign, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, swap;
    logic [EXP_W-1:0] a_exp, b_exp, x_exp, y_exp, exp_diff;
    logic [MAN_W-1:0] a_frac, b_frac, x_frac, y_frac;
    logic [W-2:0]  a_mag, b_mag;
    logic [MW-1:0] y_al;
    logic [2*MW-1:0] y_ext;
    logic          spec, spec_inv;
    logic [W-1:0]  spec_val;

    assign a_sign = in_a[W-1];
    assign b_sign = in_b[W-1] ^ op_sub;   // effective sign of B
    assign a_exp  = in_a[W-2:MAN_W];
    assign b_exp  = in_b[W-2:MAN_W];
    assign a_frac = in_a[MAN_W-1:0];
    assign b_frac = in_b[MAN_W-1:0];
    assign a_zero = (a_exp == '0);
    assign b_zero = (b_exp == '0);
    assign a_inf  = (a_exp == EXP_ONES) && (a_frac == '0);
    assign b_inf  = (b_exp == EXP_ONES) && (b_frac == '0);
    assign a_nan  = (a_exp == EXP_ONES) && (a_frac != '0);
    assign b_nan  = (b_exp == EXP_ONES) && (b_frac != '0);

    // Magnitude compare on {exp, frac}; a denormal compares as zero.
    assign a_mag  = a_zero ? '0 : in_a[W-2:0];
    assign b_mag  = b_zero ? '0 : in_b[W-2:0];
    assign swap   = (b_mag > a_mag);
    assign x_exp  = swap ? b_exp : a_exp;
    assign y_exp  = swap ? a_exp : b_exp;
    assign x_frac = swap ? b_frac : a_frac;
    assign y_frac = swap ? a_frac : b_frac;
    assign exp_diff = x_exp - y_exp;

    always_comb begin
        y_ext = {1'b1, y_frac, 3'b000, {MW{1'b0}}} >> exp_diff;
        // Beyond this distance only the sticky bit can survive.
        if (32'(exp_diff) >= 32'(MW - 1)) begin
            y_al = {{(MW-1){1'b0}}, 1'b1};
        end else begin
            y_al = {y_ext[2*MW-1:MW+1], y_ext[MW] | (|y_ext[MW-1:0])};
        end
    end

    always_comb begin
        spec     = 1'b1;
        spec_inv = 1'b0;
        spec_val = '0;
        if (a_nan || b_nan || (a_inf && b_inf && (a_sign != b_sign))) begin
            spec_val = QNAN;
            spec_inv = 1'b1;
        end else if (a_inf) begin
            spec_val = {a_sign, EXP_ONES, {MAN_W{1'b0}}};
        end else if (b_inf) begin
            spec_val = {b_sign, EXP_ONES, {MAN_W{1'b0}}};
        end else if (a_zero && b_zero) begin
            spec_val = {a_sign & b_sign, {(W-1){1'b0}}};
        end else if (a_zero) begin
            spec_val = {b_sign, in_b[W-2:0]};
        end else if (b_zero) begin
            spec_val = in_a;
        end else begin
            spec = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid    <= 1'b0;
            s1_spec     <= 1'b0;
            s1_spec_val <= '0;
            s1_sign     <= 1'b0;
            s1_sub      <= 1'b0;
            s1_exp      <= '0;
            s1_mx       <= '0;
            s1_my       <= '0;
        end else if (en) begin
            s1_valid    <= valid_in;
            s1_spec     <= spec;
            s1_spec_val <= spec_val;
            s1_sign     <= swap ? b_sign : a_sign;
            s1_sub      <= a_sign ^ b_sign;
            s1_exp      <= x_exp;
            s1_mx       <= {1'b1, x_frac, 3'b000};
            s1_my       <= y_al;
        end
    end

    // ---------------- Stage 2: add / subtract ----------------
    logic [SW-1:0] sum;
    assign sum = s1_sub ? ({1'b0, s1_mx} - {1'b0, s1_my})
                        : ({1'b0, s1_mx} + {1'b0, s1_my});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid    <= 1'b0;
            s2_spec     <= 1'b0;
            s2_spec_val <= '0;
            s2_sign     <= 1'b0;
            s2_exp      <= '0;
            s2_sum      <= '0;
        end else if (en) begin
            s2_valid    <= s1_valid;
            s2_spec     <= s1_spec;
            s2_spec_val <= s1_spec_val;
            s2_sign     <= (sum == '0) ? 1'b0 : s1_sign;   // exact cancellation gives +0
            s2_exp      <= s1_exp;
            s2_sum      <= sum;
        end
    end

    // ---------------- Stage 3: normalise / round ----------------
    logic [LZW-1:0]   lzc;
    logic [MW-1:0]    norm;
    logic [EW-1:0]    exp_n, exp_r;
    logic             inc;
    logic [MAN_W+1:0] rnd;
    logic [MAN_W-1:0] frac_r;
    logic [W-1:0]     res_d;

    always_comb begin
        lzc = LZW'(MW);
        for (int i = 0; i < MW; i++) begin
            if (s2_sum[i]) lzc = LZW'(MW - 1 - i);
        end
        if (s2_sum[SW-1]) begin
            norm  = {s2_sum[SW-1:2], s2_sum[1] | s2_sum[0]};
            exp_n = {2'b00, s2_exp} + EW'(1);
        end else begin
            norm  = s2_sum[MW-1:0] << lzc;
            exp_n = {2'b00, s2_exp} - EW'(lzc);
        end
        inc    = norm[2] & (norm[1] | norm[0] | norm[3]);
        rnd    = {1'b0, norm[MW-1:3]} + (MAN_W+2)'(inc);
        exp_r  = rnd[MAN_W+1] ? exp_n + EW'(1) : exp_n;
        frac_r = rnd[MAN_W+1] ? rnd[MAN_W:1] : rnd[MAN_W-1:0];
`ifdef FP_ADDSUB_FLAGS_EN
        s3_ovf = 1'b0;
        s3_unf = 1'b0;
`endif
        if (s2_spec) begin
            res_d = s2_spec_val;
        end else if (s2_sum == '0) begin
            res_d = '0;
        end else if (exp_n[EW-1] || (exp_n == '0)) begin
            res_d = {s2_sign, {(W-1){1'b0}}};
`ifdef FP_ADDSUB_FLAGS_EN
            s3_unf = 1'b1;
`endif
        end else if (exp_r >= {2'b00, EXP_ONES}) begin
            res_d = {s2_sign, EXP_ONES, {MAN_W{1'b0}}};
`ifdef FP_ADDSUB_FLAGS_EN
            s3_ovf = 1'b1;
`endif
        end else begin
            res_d = {s2_sign, exp_r[EXP_W-1:0], frac_r};
        end
`ifdef FP_ADDSUB_FLAGS_EN
        s3_inx = ~s2_spec & ((|norm[2:0]) | s3_ovf | s3_unf);
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s3_valid <= 1'b0;
            result   <= '0;
        end else if (en) begin
            s3_valid <= s2_valid;
            result   <= res_d;
        end
    end

`ifdef FP_ADDSUB_FLAGS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_inv <= 1'b0;
            s2_inv <= 1'b0;
            flags  <= '0;
        end else if (en) begin
            s1_inv <= spec_inv;
            s2_inv <= s1_inv;
            flags  <= {s2_spec & s2_inv, ~s2_spec & s3_ovf, ~s2_spec & s3_unf, s3_inx};
        end
    end
`else
    logic unused_inv;
    assign unused_inv = spec_inv;
`endif

endmodule

// File: tb/tb_fp_addsub_pipe.sv
// tb_fp_addsub_pipe
//   Bench for fp_addsub_pipe at EXP_W=8, MAN_W=23.
//   It applies a table of directed vectors and then randomized operations.
//   The random operations run with random downstream backpressure.
//   It also covers latency, stall-hold and mid-flight reset sequences.
//   Expected values for random operations come from an exact-integer
//   reference model: the sum is computed exactly, then rounded once.
module tb_fp_addsub_pipe;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] in_a, in_b;
    logic        op_sub, valid_in, ready_out, valid_out, ready_in;
    logic [31:0] result;
`ifdef FP_ADDSUB_FLAGS_EN
    logic [3:0]  flags;
`endif

    fp_addsub_pipe #(.EXP_W(8), .MAN_W(23)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_a     (in_a),
        .in_b     (in_b),
        .op_sub   (op_sub),
        .valid_in (valid_in),
        .ready_out(ready_out),
        .result   (result),
        .valid_out(valid_out),
        .ready_in (ready_in)
`ifdef FP_ADDSUB_FLAGS_EN
        ,
        .flags    (flags)
`endif
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int          total = 0;
    int          bad = 0;
    int          rx_cnt = 0;
    bit          rnd_done = 1'b0;
    logic [35:0] exp_q[$];          // {flags, result}
    logic [35:0] mon_e;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic [31:0] res;
        logic [3:0]  flg;
    } vec_t;

    task automatic check(input string name, input logic [35:0] got, input logic [35:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    // Reference: exact sum in units of 2^-149, then a single RNE rounding.
    function automatic logic [35:0] ref_model(input logic [31:0] a, input logic [31:0] b,
                                              input logic sub);
        logic        sa, sb, s;
        int          ea, eb, p, be;
        logic [22:0] fa, fb;
        logic [299:0] ma, mb, mag, rem, half, one, q;
        logic        inx;
        sa = a[31]; sb = b[31] ^ sub;
        ea = int'(a[30:23]); eb = int'(b[30:23]);
        fa = a[22:0]; fb = b[22:0];
        if ((ea == 255 && fa != 0) || (eb == 255 && fb != 0) || (ea == 255 && eb == 255 && sa != sb))
            return {4'b1000, 32'h7FC00000};
        if (ea == 255) return {4'b0000, sa, 8'hFF, 23'h0};
        if (eb == 255) return {4'b0000, sb, 8'hFF, 23'h0};
        if (ea == 0 && eb == 0) return {4'b0000, sa & sb, 31'h0};
        if (ea == 0) return {4'b0000, sb, b[30:0]};
        if (eb == 0) return {4'b0000, a};
        one = 300'(1);
        ma = 300'({1'b1, fa}) << (ea - 1);
        mb = 300'({1'b1, fb}) << (eb - 1);
        if (sa == sb) begin mag = ma + mb; s = sa; end
        else if (ma >= mb) begin mag = ma - mb; s = sa; end
        else begin mag = mb - ma; s = sb; end
        if (mag == 0) return 36'h0;
        p = 0;
        for (int i = 0; i < 300; i++) if (mag[i]) p = i;
        be = p - 22;
        if (be <= 0) return {4'b0011, s, 31'h0};
        q   = mag >> (p - 23);
        rem = mag & ((one << (p - 23)) - one);
        inx = (rem != 0);
        if (p > 23) begin
            half = one << (p - 24);
            if (rem > half || (rem == half && q[0])) q = q + one;
        end
        if (q[24]) begin q = q >> 1; be++; end
        if (be >= 255) return {4'b0101, s, 8'hFF, 23'h0};
        return {3'b000, inx, s, 8'(be), q[22:0]};
    endfunction

    function automatic logic [31:0] rnd_fp(input int base);
        int          e, r;
        logic [22:0] f;
        r = int'($urandom_range(0, 15));
        f = 23'($urandom);
        if (r == 0) e = 0;
        else if (r == 1) begin
            e = 255;
            if ($urandom_range(0, 1) == 0) f = '0;
        end else begin
            e = base + int'($urandom_range(0, 60)) - 30;
            if (e < 1) e = 1;
            if (e > 254) e = 254;
        end
        return {1'($urandom_range(0, 1)), 8'(e), f};
    endfunction

    // ---------------- driver tasks (call aligned to posedge+1) ----------------
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input logic [35:0] e);
        bit acc;
        int guard;
        in_a = a; in_b = b; op_sub = s; valid_in = 1'b1;
        acc = 1'b0; guard = 0;
        while (!acc && guard < 200) begin
            @(negedge clk);
            acc = ready_out;
            @(posedge clk);
            #1;
            guard++;
        end
        if (acc) exp_q.push_back(e);
        else begin
            total++; bad++;
            $display("FAIL send_timeout got=not_accepted want=accepted a=%h", a);
        end
        valid_in = 1'b0;
    endtask

    task automatic drain(input string name);
        int guard;
        guard = 0;
        ready_in = 1'b1;
        while (exp_q.size() != 0 && guard < 200) begin
            @(posedge clk);
            #1;
            guard++;
        end
        check({name, "_drain_pending"}, 36'(exp_q.size()), 36'h0);
    endtask

    // ---------------- output monitor ----------------
    always @(negedge clk) begin
        if (rst_n && valid_out && ready_in) begin
            rx_cnt++;
            if (exp_q.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_output got=%h want=none", result);
            end else begin
                mon_e = exp_q.pop_front();
                check("result", {4'h0, result}, {4'h0, mon_e[31:0]});
`ifdef FP_ADDSUB_FLAGS_EN
                check("flags", {32'h0, flags}, {32'h0, mon_e[35:32]});
`endif
            end
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        vec_t        tbl[20];
        logic [31:0] ra, rb, st_a;
        logic        rs;
        logic [35:0] st_e0;
        int          base, mode, rx_start;

        tbl[0]  = '{32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 4'b0000};
        tbl[1]  = '{32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 4'b0000};
        tbl[2]  = '{32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'b0001};
        tbl[3]  = '{32'h3F800000, 32'h33C00000, 1'b0, 32'h3F800001, 4'b0001};
        tbl[4]  = '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'b0101};
        tbl[5]  = '{32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 4'b1000};
        tbl[6]  = '{32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'b0000};
        tbl[7]  = '{32'h00400000, 32'h00000000, 1'b0, 32'h00000000, 4'b0000};
        tbl[8]  = '{32'hC0400000, 32'h40000000, 1'b0, 32'hBF800000, 4'b0000};
        tbl[9]  = '{32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b1000};
        tbl[10] = '{32'hFF800000, 32'h3F800000, 1'b0, 32'hFF800000, 4'b0000};
        tbl[11] = '{32'h3F800000, 32'hFF800000, 1'b1, 32'h7F800000, 4'b0000};
        tbl[12] = '{32'h00000000, 32'h3F800000, 1'b1, 32'hBF800000, 4'b0000};
        tbl[13] = '{32'h80000000, 32'h00000000, 1'b1, 32'h80000000, 4'b0000};
        tbl[14] = '{32'h40000000, 32'h3F800000, 1'b1, 32'h3F800000, 4'b0000};
        tbl[15] = '{32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 4'b0000};
        tbl[16] = '{32'h00800000, 32'h00800001, 1'b1, 32'h80000000, 4'b0011};
        tbl[17] = '{32'h7F000000, 32'h7F000000, 1'b0, 32'h7F800000, 4'b0101};
        tbl[18] = '{32'h3F800000, 32'h7F800000, 1'b0, 32'h7F800000, 4'b0000};
        tbl[19] = '{32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 4'b0001};

        in_a = '0; in_b = '0; op_sub = 1'b0; valid_in = 1'b0; ready_in = 1'b1;

        // reset
        repeat (3) @(posedge clk);
        #1;
        check("reset_valid_out", 36'(valid_out), 36'h0);
        check("reset_result", {4'h0, result}, 36'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("ready_after_reset", 36'(ready_out), 36'h1);

        // latency: accepted at edge 0, visible after edge 2, gone after edge 3
        in_a = 32'h3F800000; in_b = 32'h40000000; op_sub = 1'b0; valid_in = 1'b1;
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        exp_q.push_back({4'b0000, 32'h40400000});
        @(negedge clk); check("lat_cycle1_valid", 36'(valid_out), 36'h0);
        @(negedge clk); check("lat_cycle2_valid", 36'(valid_out), 36'h0);
        @(negedge clk); check("lat_cycle3_valid", 36'(valid_out), 36'h1);
        @(negedge clk); check("lat_cycle4_valid", 36'(valid_out), 36'h0);
        @(posedge clk);
        #1;

        // directed table, streamed back to back
        for (int i = 0; i < 20; i++)
            send(tbl[i].a, tbl[i].b, tbl[i].sub, {tbl[i].flg, tbl[i].res});
        drain("table");

        // randomized operations with random backpressure
        rnd_done = 1'b0;
        fork
            begin
                for (int n = 0; n < 300; n++) begin
                    base = int'($urandom_range(1, 254));
                    ra   = rnd_fp(base);
                    mode = int'($urandom_range(0, 9));
                    if (mode == 0) rb = ra;
                    else if (mode == 1) rb = ra ^ 32'h1;
                    else rb = rnd_fp(base);
                    rs = 1'($urandom_range(0, 1));
                    send(ra, rb, rs, ref_model(ra, rb, rs));
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    ready_in = ($urandom_range(0, 3) != 0);
                    @(posedge clk);
                    #1;
                end
            end
        join
        drain("random");

        // stall: six back-to-back ops, downstream blocked for four cycles
        ready_in = 1'b1;
        rx_start = rx_cnt;
        st_e0 = ref_model(32'h40000000, 32'h3F800000, 1'b0);
        fork
            begin
                for (int k = 0; k < 6; k++) begin
                    st_a = 32'h40000000 + (32'(k) << 20);
                    send(st_a, 32'h3F800000, 1'b0, ref_model(st_a, 32'h3F800000, 1'b0));
                end
            end
            begin
                repeat (3) @(posedge clk);
                #1;
                ready_in = 1'b0;
                for (int j = 0; j < 4; j++) begin
                    @(negedge clk);
                    check("stall_valid_out", 36'(valid_out), 36'h1);
                    check("stall_ready_out", 36'(ready_out), 36'h0);
                    check("stall_result_hold", {4'h0, result}, {4'h0, st_e0[31:0]});
                    @(posedge clk);
                end
                #1;
                ready_in = 1'b1;
            end
        join
        drain("stall");
        check("stall_output_count", 36'(rx_cnt - rx_start), 36'd6);

        // asynchronous reset with two ops in flight
        ready_in = 1'b0;
        send(32'h3F800000, 32'h3F800000, 1'b0, {4'b0000, 32'h40000000});
        send(32'h40000000, 32'h40000000, 1'b0, {4'b0000, 32'h40800000});
        @(posedge clk);
        #2;
        check("pre_reset_valid_out", 36'(valid_out), 36'h1);
        rst_n = 1'b0;
        #1;
        check("async_reset_valid_out", 36'(valid_out), 36'h0);
        check("async_reset_result", {4'h0, result}, 36'h0);
        exp_q.delete();
        #2;
        rst_n = 1'b1;
        ready_in = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("post_reset_no_output", 36'(valid_out), 36'h0);
        end
        @(posedge clk);
        #1;
        check("post_reset_ready_out", 36'(ready_out), 36'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
